ysyx_220053_mdu: RTL and testbench

Iterative RV64M multiply/divide unit for the npc core. It sits downstream of the decoder and executes the operations the decoder marks as M-extension (ALUOp 5'b01001 / 5'b11001 with func7 = 0000001). It takes operands and func3 through a valid/ready handshake and runs a radix-2 shift-add or shift-subtract sequence for 64 iterations. It returns a 64-bit result to writeback under a second valid/ready handshake. The execute stage stalls on `in_ready`/`out_valid`.

---
 rtl/ysyx_220053_defs.sv | 26 ++
 rtl/ysyx_220053_mdu_iter.sv | 57 +++++
 rtl/ysyx_220053_mdu.sv | 143 ++++++++++++++
 tb/tb_ysyx_220053_mdu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_defs.sv
// Shared constants for the RV64M multiply/divide unit.
// Holds func3 encodings, FSM states and the datapath width.
package ysyx_220053_defs;

    localparam int XLEN = 64;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_220053_mdu_iter.sv
// Radix-2 iteration datapath: shared 128-bit accumulator/remainder,
// shift-add for multiply and restoring shift-subtract for divide.
module ysyx_220053_mdu_iter
    import ysyx_220053_defs::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_init,
    input  logic [XLEN-1:0]     b_init,
    output logic [2*XLEN-1:0]   acc,
    output logic                last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] b;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] sub;
    logic            ge;
    logic [2*XLEN-1:0] nxt;

    always_comb begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b};
        // shifted partial remainder is 65 bits wide before the compare
        ge  = acc[2*XLEN-1:XLEN-1] >= {1'b0, b};
        sub = acc[2*XLEN-2:XLEN-1] - b;
        if (is_div) begin
            nxt = {ge ? sub : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], ge};
        end else if (acc[0]) begin
            nxt = {sum, acc[XLEN-1:1]};
        end else begin
            nxt = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    assign last = (cnt == CW'(XLEN-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            b   <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= acc_init;
            b   <= b_init;
            cnt <= '0;
        end else if (step) begin
            acc <= nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_220053_mdu.sv
// Iterative RV64M multiply/divide unit with valid/ready on both sides.
// Top holds FSM, operand preparation, special cases and sign fix.
module ysyx_220053_mdu
    import ysyx_220053_defs::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_t state, state_nxt;

    logic [2:0] op;
    logic       word, neg, bad, res_ok;

    logic            s1, s2, neg_a, neg_b, div0, ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, ma, mb, a_min, v, q, r;
    logic [2*XLEN-1:0] acc_init, acc, p;
    logic            last;

    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        unique case (func3)
            MUL:    begin s1 = 1'b1; s2 = 1'b1; end
            MULH:   begin s1 = 1'b1; s2 = 1'b1; end
            MULHSU: begin s1 = 1'b1; s2 = 1'b0; end
            MULHU:  begin s1 = 1'b0; s2 = 1'b0; end
            DIV:    begin s1 = 1'b1; s2 = 1'b1; end
            DIVU:   begin s1 = 1'b0; s2 = 1'b0; end
            REM:    begin s1 = 1'b1; s2 = 1'b1; end
            REMU:   begin s1 = 1'b0; s2 = 1'b0; end
        endcase
        // mulw only needs the low product bits, so its operands stay unsigned
        if (is_word && !func3[2]) begin
            s1 = 1'b0;
            s2 = 1'b0;
        end
    end

    always_comb begin
        a_ext = src1;
        b_ext = src2;
        if (is_word) begin
            a_ext = s1 ? sext_w(src1) : {{(XLEN-32){1'b0}}, src1[31:0]};
            b_ext = s2 ? sext_w(src2) : {{(XLEN-32){1'b0}}, src2[31:0]};
        end
        neg_a = s1 & a_ext[XLEN-1];
        neg_b = s2 & b_ext[XLEN-1];
        ma    = neg_a ? -a_ext : a_ext;
        mb    = neg_b ? -b_ext : b_ext;
        a_min = is_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                        : {1'b1, {(XLEN-1){1'b0}}};
        div0    = func3[2] && (b_ext == '0);
        ovf     = func3[2] && s1 && (a_ext == a_min) && (&b_ext);
        special = div0 | ovf;
        if (div0) begin
            acc_init = {a_ext, {XLEN{1'b1}}};
        end else begin
            acc_init = {{XLEN{1'b0}}, ovf ? a_ext : ma};
        end
    end

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE) && res_ok;

    ysyx_220053_mdu_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     ((state == BUSY) && !flush),
        .is_div   (op[2]),
        .acc_init (acc_init),
        .b_init   (mb),
        .acc      (acc),
        .last     (last)
    );

    always_comb begin
        p = neg ? -acc : acc;
        q = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (op[2]) begin
            v = op[1] ? r : q;
        end else begin
            v = (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        if (word) v = sext_w(v);
        if (bad) v = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = special ? DONE : BUSY;
            BUSY: if (last) state_nxt = DONE;
            DONE: if (res_ok && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            word   <= 1'b0;
            neg    <= 1'b0;
            bad    <= 1'b0;
            res_ok <= 1'b0;
            result <= '0;
        end else if (flush) begin
            res_ok <= 1'b0;
        end else if (accept) begin
            op     <= func3;
            word   <= is_word;
            neg    <= special ? 1'b0
                    : (func3[2] & func3[1]) ? neg_a : (neg_a ^ neg_b);
            bad    <= is_word && !func3[2] && (func3[1:0] != 2'b00);
            res_ok <= 1'b0;
        end else if ((state == DONE) && !res_ok) begin
            result <= v;
            res_ok <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_mdu.sv
// Directed self-checking bench for the RV64M multiply/divide unit.
// Expected values are hand-computed constants.
module tb_ysyx_220053_mdu;
    import ysyx_220053_defs::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, is_word, flush;
    logic        out_valid, out_ready, busy;
    logic [2:0]  func3;
    logic [63:0] src1, src2, result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_220053_mdu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func3     (func3),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        func3    = f3;
        is_word  = w;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = ~a;
        src2     = ~b;
        func3    = ~f3;
    endtask

    task automatic run(input string tag, input logic [2:0] f3,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int lat, input int hold);
        int n;
        logic low_ok, stable;
        logic [63:0] r0;
        n = 0;
        low_ok = 1'b1;
        stable = 1'b1;
        issue(f3, w, a, b);
        while (!out_valid && n < 200) begin
            low_ok &= !in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_rdylow"}, {63'd0, low_ok}, 64'd1);
        r0 = result;
        repeat (hold) begin
            @(posedge clk);
            #1;
            stable &= (result === r0) && out_valid && !in_ready;
        end
        if (hold > 0) chk({tag, "_hold"}, {63'd0, stable}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_hs_vld"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_hs_rdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        is_word   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        func3     = '0;
        src1      = '0;
        src2      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);
        chk("rst_vld", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_res", result, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("mul", MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
            64'hFFFF_FFFF_FFFF_FFF1, 65, 0);
        run("mulhu", MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run("mulh", MULH, 1'b0, '1, '1, 64'd0, 65, 0);
        run("mulhsu", MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run("mulw", MUL, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        run("div", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run("rem", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run("divuw", DIVU, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2,
            64'h0000_0000_7FFF_FFFF, 65, 0);
        run("illegal", MULH, 1'b1, 64'd7, 64'd9, 64'd0, 65, 0);

        run("divu0", DIVU, 1'b0, 64'd42, 64'd0, '1, 1, 0);
        run("remu0", REMU, 1'b0, 64'd42, 64'd0, 64'd42, 1, 0);
        run("divovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
            64'h8000_0000_0000_0000, 1, 0);
        run("divwovf", DIV, 1'b1, 64'h0000_0000_8000_0000, '1,
            64'hFFFF_FFFF_8000_0000, 1, 0);

        run("bp", MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 10);
        run("after_bp", MUL, 1'b0, 64'd6, 64'd7, 64'd42, 65, 0);

        issue(DIV, 1'b0, 64'd100, 64'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_rdy", {63'd0, in_ready}, 64'd1);
        chk("fl_vld", {63'd0, out_valid}, 64'd0);
        chk("fl_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        chk("fl_novld", {63'd0, seen}, 64'd0);
        run("fl_mul", MUL, 1'b0, 64'd11, 64'd13, 64'd143, 65, 0);

        issue(DIV, 1'b0, 64'd100, 64'd3);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rs_rdy", {63'd0, in_ready}, 64'd1);
        chk("rs_vld", {63'd0, out_valid}, 64'd0);
        chk("rs_busy", {63'd0, busy}, 64'd0);
        chk("rs_res", result, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        chk("rs_novld", {63'd0, seen}, 64'd0);
        run("rs_mul", MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5,
            64'hFFFF_FFFF_FFFF_FFF6, 65, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
